// File: rtl/uart_rx_basic.sv
// 8N1 UART receiver: 2-FF synchronised rx, mid-bit sampling, framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (8E1).
module uart_rx_basic #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int N  = CLK_FREQ / BAUD_RATE;
  localparam int H  = N / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] N_M1 = CW'(N - 1);
  localparam logic [CW-1:0] H_M1 = CW'(H - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // rx is asynchronous to clk; both flops reset to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      parity_bad <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end

        START: begin
          if (cnt == H_M1) begin
            cnt   <= '0;
            // a start bit that has gone high again by mid-bit is a glitch
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == N_M1) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == N_M1) begin
            cnt        <= '0;
            parity_bad <= ^{shift, rx_s};
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == N_M1) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shift;
              valid    <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= parity_bad;
`endif
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // a break or stuck-low line must go high before another start is accepted
        WAIT_HI: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_basic.sv
// Scoreboard bench for uart_rx_basic: stimulus pushes expected frames, a monitor pops on each pulse.
`timescale 1ns/1ps
module tb_uart_rx_basic;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int N         = CLK_FREQ / BAUD_RATE;
  localparam int H         = N / 2;
  localparam int PERIOD    = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN    = 1'b1;
  localparam int FBITS     = 10;
`else
  localparam bit PAR_EN    = 1'b0;
  localparam int FBITS     = 9;
`endif
  // latency in half clock periods from the rx falling edge to the edge that raises the pulse
  localparam int LAT_HALF  = 2 * (2 + H + FBITS * N);

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_basic #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         perr;
    longint     t0;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_good = 8'h00;

  initial begin
    clk = 1'b0;
    forever #(PERIOD/2) clk = ~clk;
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = d;
    e.perr   = PAR_EN && stop_ok && ((^d) != par);
    e.t0     = $time;
    q.push_back(e);
    $display("frame data=%02h stop=%0b par=%0b expect %s", d, stop_ok, par,
             stop_ok ? "valid" : "frame_err");
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par;
      repeat (N) @(negedge clk);
    end
    rx = stop_ok;
    repeat (N) @(negedge clk);
  endtask

  task automatic idle_bits(input int nbits);
    rx = 1'b1;
    repeat (nbits * N) @(negedge clk);
  endtask

  task automatic glitch(input int g);
    bit seen;
    seen = 1'b0;
    $display("glitch low for %0d clocks", g);
    rx = 1'b0;
    repeat (g) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", 32'(seen), 32'd1);
    chk("glitch_idle_after", 32'(busy), 32'd0);
  endtask

  // monitor: compares every pulse against the head of the scoreboard queue
  initial begin
    exp_t   e;
    longint lat;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_good = 8'h00;
        chk("reset_outputs", {20'd0, data_out, valid, frame_err, parity_err, busy}, 32'd0);
        continue;
      end
      if (valid && frame_err) chk("valid_with_frame_err", 32'd1, 32'd0);
      if (parity_err && !valid) chk("parity_err_without_valid", 32'd1, 32'd0);
      if (valid || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {30'd0, valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) begin
            chk("data_out", {24'd0, data_out}, {24'd0, e.data});
            chk("parity_err", 32'(parity_err), 32'(e.perr));
            last_good = e.data;
          end else begin
            chk("parity_err_on_frame_err", 32'(parity_err), 32'd0);
          end
          lat = (($time - 1) - e.t0) / (PERIOD / 2);
          chk("latency_in_window", 32'((lat >= LAT_HALF - 2) && (lat <= LAT_HALF + 2)), 32'd1);
          $display("pulse %s data_out=%02h parity_err=%0b latency_half_clocks=%0d",
                   valid ? "valid" : "frame_err", data_out, parity_err, lat);
        end
      end
      chk("data_out_hold", {24'd0, data_out}, {24'd0, last_good});
    end
  end

  initial begin
    logic [7:0] d;
    int         kind;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data_out", {24'd0, data_out}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // single frame
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_bits(1);
    chk("busy_after_frame", 32'(busy), 32'd0);

    // back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(2);

    // short low glitch aborts in START
    glitch(3);

    // framing error followed by a long stuck-low line
    send_frame(8'h12, 1'b0, ^8'h12);
    rx = 1'b0;
    repeat (30 * N) @(negedge clk);
    chk("wait_hi_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("wait_hi_released", 32'(busy), 32'd0);
    idle_bits(1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
`endif

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      d    = 8'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_frame(d, 1'b0, 1'($urandom));
        rx = 1'b0;
        repeat ($urandom_range(0, 3) * N) @(negedge clk);
        idle_bits(1);
      end else if (kind == 1) begin
        glitch($urandom_range(1, 3));
      end else begin
        send_frame(d, 1'b1, 1'($urandom));
        idle_bits($urandom_range(0, 2));
      end
    end
    idle_bits(2);

    // reset in the middle of data bit 4, then a normal frame
    $display("frame data=81 aborted by reset during bit 4");
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : (i == 0);
      repeat (N) @(negedge clk);
    end
    rx = 1'b0;
    repeat (H) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_data_out", {24'd0, data_out}, 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rx    = 1'b1;
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle_bits(3);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
